// File: rtl/sbox_config_loader_if.sv
// Byte-stream command port plus the shared S-box edit bus and status flags.
// The loader connects through the slave modport; the host side uses master.
interface sbox_config_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       edit_sbox;
  logic [2:0] sbox_sel;
  logic [1:0] row_sel;
  logic [3:0] col_sel;
  logic [3:0] new_sbox_val;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output s_valid, s_data,
    input  s_ready, edit_sbox, sbox_sel, row_sel, col_sel, new_sbox_val,
           busy, done, err
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, edit_sbox, sbox_sel, row_sel, col_sel, new_sbox_val,
           busy, done, err
  );
endinterface

// File: rtl/sbox_config_loader.sv
// Decodes single/row/full-table S-box load commands from a byte stream and
// issues one registered edit per cycle on the shared S-box edit bus.
module sbox_config_loader (
  input  logic                 clk,
  input  logic                 rst_n,
  sbox_config_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GET    = 3'd1;
  localparam logic [2:0] S_WR_ONE = 3'd2;
  localparam logic [2:0] S_WR_HI  = 3'd3;
  localparam logic [2:0] S_WR_LO  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] OP_SINGLE = 2'd0;
  localparam logic [1:0] OP_ROW    = 2'd1;
  localparam logic [1:0] OP_TABLE  = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] sbox_q, sbox_d;
  logic [1:0] row_q, row_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] lo_nib_q, lo_nib_d;

  logic       edit_q, edit_d;
  logic [2:0] sbox_sel_q, sbox_sel_d;
  logic [1:0] row_sel_q, row_sel_d;
  logic [3:0] col_sel_q, col_sel_d;
  logic [3:0] val_q, val_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       ready;
  logic       accept;
  logic       last_pair;
  logic [5:0] lo_idx;

  assign ready  = (state_q == S_IDLE) || (state_q == S_GET);
  assign accept = bus.s_valid && ready;

  // idx_q always points at the high-nibble entry of the current byte
  assign lo_idx    = {idx_q[5:1], 1'b1};
  assign last_pair = ((op_q == OP_ROW)   && (idx_q[3:0] == 4'd14)) ||
                     ((op_q == OP_TABLE) && (idx_q == 6'd62));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sbox_d     = sbox_q;
    row_d      = row_q;
    idx_d      = idx_q;
    lo_nib_d   = lo_nib_q;
    edit_d     = 1'b0;
    sbox_sel_d = 3'd0;
    row_sel_d  = 2'd0;
    col_sel_d  = 4'd0;
    val_d      = 4'd0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.s_data[7:6] == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            op_d    = bus.s_data[7:6];
            sbox_d  = bus.s_data[5:3];
            row_d   = bus.s_data[2:1];
            idx_d   = 6'd0;
            state_d = S_GET;
          end
        end
      end

      // The first edit of a byte is launched on the accepting edge so it
      // appears in the very next cycle.
      S_GET: begin
        if (accept) begin
          lo_nib_d   = bus.s_data[3:0];
          edit_d     = 1'b1;
          sbox_sel_d = sbox_q;
          if (op_q == OP_SINGLE) begin
            row_sel_d = row_q;
            col_sel_d = bus.s_data[7:4];
            val_d     = bus.s_data[3:0];
            state_d   = S_WR_ONE;
          end else begin
            row_sel_d = (op_q == OP_ROW) ? row_q : idx_q[5:4];
            col_sel_d = idx_q[3:0];
            val_d     = bus.s_data[7:4];
            state_d   = S_WR_HI;
          end
        end
      end

      S_WR_ONE: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_WR_HI: begin
        edit_d     = 1'b1;
        sbox_sel_d = sbox_q;
        row_sel_d  = (op_q == OP_ROW) ? row_q : lo_idx[5:4];
        col_sel_d  = lo_idx[3:0];
        val_d      = lo_nib_q;
        state_d    = S_WR_LO;
      end

      S_WR_LO: begin
        idx_d = idx_q + 6'd2;
        if (last_pair) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_GET;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_SINGLE;
      sbox_q     <= 3'd0;
      row_q      <= 2'd0;
      idx_q      <= 6'd0;
      lo_nib_q   <= 4'd0;
      edit_q     <= 1'b0;
      sbox_sel_q <= 3'd0;
      row_sel_q  <= 2'd0;
      col_sel_q  <= 4'd0;
      val_q      <= 4'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sbox_q     <= sbox_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      lo_nib_q   <= lo_nib_d;
      edit_q     <= edit_d;
      sbox_sel_q <= sbox_sel_d;
      row_sel_q  <= row_sel_d;
      col_sel_q  <= col_sel_d;
      val_q      <= val_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.s_ready      = ready;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.edit_sbox    = edit_q;
  assign bus.sbox_sel     = sbox_sel_q;
  assign bus.row_sel      = row_sel_q;
  assign bus.col_sel      = col_sel_q;
  assign bus.new_sbox_val = val_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_sbox_config_loader.sv
// Bench for sbox_config_loader: table vectors, hand-written corner sequences and
// random commands compared against a command-level model of the edit stream.
module tb_sbox_config_loader;
  localparam int HIST = 65536;

  typedef struct {
    logic [12:0] f;
    int          stamp;
  } edit_t;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] dat;
    bit         rsv;
    logic [2:0] sb;
    logic [1:0] row;
    logic [3:0] col;
    logic [3:0] val;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sbox_config_loader_if bus();

  sbox_config_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  int cyc      = 0;

  edit_t      edit_q[$];
  edit_t      exp_q[$];
  int         done_q[$];
  int         err_q[$];
  int         acc_q[$];
  int         exp_done[$];
  int         exp_err[$];
  logic [7:0] acc_data_q[$];
  logic [7:0] sent_q[$];
  logic       ready_hist [HIST];
  logic [3:0] sbox_mem [8][4][16];

  always @(posedge clk) cyc <= cyc + 1;

  // Stamps are the edge count at the sampling negedge; an accept is stamped
  // with the edge that performs the transfer.
  always @(negedge clk) begin
    if (cyc < HIST) ready_hist[cyc] <= bus.s_ready;
    if (bus.edit_sbox) begin
      edit_q.push_back('{f: {bus.sbox_sel, bus.row_sel, bus.col_sel, bus.new_sbox_val}, stamp: cyc});
      sbox_mem[bus.sbox_sel][bus.row_sel][bus.col_sel] <= bus.new_sbox_val;
    end
    if (bus.done) done_q.push_back(cyc);
    if (bus.err) err_q.push_back(cyc);
    if (rst_n && bus.s_valid && bus.s_ready) begin
      acc_q.push_back(cyc + 1);
      acc_data_q.push_back(bus.s_data);
    end
    if ((bus.done && bus.err) || (bus.edit_sbox && (bus.done || bus.err)) ||
        (!bus.edit_sbox && (|{bus.sbox_sel, bus.row_sel, bus.col_sel, bus.new_sbox_val}))) begin
      viol <= viol + 1;
      $display("[TB] invariant broken at cycle %0d", cyc);
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [12:0] pack_edit(input int sb, input int r, input int c, input int v);
    return {3'(sb), 2'(r), 4'(c), 4'(v)};
  endfunction

  function automatic logic rdy(input int s);
    if (s < 0 || s >= HIST) return 1'b0;
    return ready_hist[s];
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic clear_logs();
    edit_q.delete();
    done_q.delete();
    err_q.delete();
    acc_q.delete();
    acc_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard = 0;
    if (gap_pct > 0) begin
      bus.s_valid = 1'b0;
      while (!bus.s_ready && guard < 200) begin @(posedge clk); #1; guard++; end
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
        @(posedge clk); #1;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!bus.s_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    if (!bus.s_ready) begin
      checkOutput("accept_timeout", int'(bus.s_ready), 1);
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd[$], input int gap_pct);
    int guard = 0;
    clear_logs();
    sent_q = cmd;
    foreach (cmd[i]) send_byte(cmd[i], gap_pct);
    bus.s_valid = 1'b0;
    while (bus.busy && guard < 400) begin @(posedge clk); #1; guard++; end
    if (bus.busy) checkOutput("idle_timeout", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Expands the sent bytes into the edits, done/err pulses and s_ready
  // pattern the command rules imply, anchored to the observed accept edges.
  task automatic compareRun(input string tag);
    int p, op, nb, d, hs, ix, ready_bad, order_bad, n;
    logic [7:0] h, b;
    logic [2:0] sb;
    logic [1:0] rw;
    int r, c, v;
    bit last;
    ready_bad = 0;
    order_bad = 0;
    exp_q.delete(); exp_done.delete(); exp_err.delete();
    checkOutput({tag, " accepted_bytes"}, acc_data_q.size(), sent_q.size());
    if (acc_data_q.size() != sent_q.size()) return;
    foreach (sent_q[i]) if (acc_data_q[i] != sent_q[i]) order_bad++;
    p = 0;
    while (p < sent_q.size()) begin
      h  = sent_q[p];
      hs = acc_q[p];
      op = int'(h[7:6]);
      sb = h[5:3];
      rw = h[2:1];
      if (rdy(hs) !== 1'b1) ready_bad++;
      p++;
      if (op == 3) begin
        exp_err.push_back(hs);
        continue;
      end
      nb = (op == 0) ? 1 : (op == 1) ? 8 : 32;
      for (int k = 0; k < nb && p + k < sent_q.size(); k++) begin
        b    = sent_q[p + k];
        d    = acc_q[p + k];
        last = (k == nb - 1);
        if (rdy(d) !== 1'b0 || rdy(d + 1) !== 1'b0) ready_bad++;
        if (op == 0) begin
          exp_q.push_back('{f: pack_edit(sb, rw, b[7:4], b[3:0]), stamp: d});
          exp_done.push_back(d + 1);
          if (rdy(d + 2) !== 1'b1) ready_bad++;
        end else begin
          for (int nib = 0; nib < 2; nib++) begin
            ix = 2 * k + nib;
            v  = (nib == 0) ? int'(b[7:4]) : int'(b[3:0]);
            r  = (op == 1) ? int'(rw) : ix / 16;
            c  = (op == 1) ? ix : ix % 16;
            exp_q.push_back('{f: pack_edit(sb, r, c, v), stamp: d + nib});
          end
          if (last) begin
            exp_done.push_back(d + 2);
            if (rdy(d + 2) !== 1'b0 || rdy(d + 3) !== 1'b1) ready_bad++;
          end else if (rdy(d + 2) !== 1'b1) begin
            ready_bad++;
          end
        end
      end
      p += nb;
    end
    checkOutput({tag, " byte_order_errors"}, order_bad, 0);
    checkOutput({tag, " edit_count"}, edit_q.size(), exp_q.size());
    n = (edit_q.size() < exp_q.size()) ? edit_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s edit%0d_fields", tag, i), int'(edit_q[i].f), int'(exp_q[i].f));
      checkOutput($sformatf("%s edit%0d_cycle", tag, i), edit_q[i].stamp, exp_q[i].stamp);
    end
    checkOutput({tag, " done_count"}, done_q.size(), exp_done.size());
    if (done_q.size() == exp_done.size())
      foreach (done_q[i]) checkOutput({tag, " done_cycle"}, done_q[i], exp_done[i]);
    checkOutput({tag, " err_count"}, err_q.size(), exp_err.size());
    if (err_q.size() == exp_err.size())
      foreach (err_q[i]) checkOutput({tag, " err_cycle"}, err_q[i], exp_err[i]);
    checkOutput({tag, " ready_pattern_errors"}, ready_bad, 0);
  endtask

  vec_t       vecs[8];
  logic [7:0] cmd[$];
  logic [7:0] rnd8;
  int         op, nb, spacing_bad;

  initial begin
    vecs[0] = '{hdr: 8'h08, dat: 8'h5A, rsv: 1'b0, sb: 3'd1, row: 2'd0, col: 4'h5, val: 4'hA};
    vecs[1] = '{hdr: 8'h08, dat: 8'h3C, rsv: 1'b0, sb: 3'd1, row: 2'd0, col: 4'h3, val: 4'hC};
    vecs[2] = '{hdr: 8'h3F, dat: 8'hF0, rsv: 1'b0, sb: 3'd7, row: 2'd3, col: 4'hF, val: 4'h0};
    vecs[3] = '{hdr: 8'h16, dat: 8'h91, rsv: 1'b0, sb: 3'd2, row: 2'd3, col: 4'h9, val: 4'h1};
    vecs[4] = '{hdr: 8'h22, dat: 8'h7E, rsv: 1'b0, sb: 3'd4, row: 2'd1, col: 4'h7, val: 4'hE};
    vecs[5] = '{hdr: 8'h0D, dat: 8'h00, rsv: 1'b0, sb: 3'd1, row: 2'd2, col: 4'h0, val: 4'h0};
    vecs[6] = '{hdr: 8'hC0, dat: 8'h00, rsv: 1'b1, sb: 3'd0, row: 2'd0, col: 4'h0, val: 4'h0};
    vecs[7] = '{hdr: 8'hFF, dat: 8'h00, rsv: 1'b1, sb: 3'd0, row: 2'd0, col: 4'h0, val: 4'h0};

    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    repeat (6) begin
      @(posedge clk); #1;
      bus.s_valid = ~bus.s_valid;
      bus.s_data  = 8'($urandom);
    end
    checkOutput("rst edit_sbox", int'(bus.edit_sbox), 0);
    checkOutput("rst sbox_sel", int'(bus.sbox_sel), 0);
    checkOutput("rst row_sel", int'(bus.row_sel), 0);
    checkOutput("rst col_sel", int'(bus.col_sel), 0);
    checkOutput("rst new_sbox_val", int'(bus.new_sbox_val), 0);
    checkOutput("rst busy", int'(bus.busy), 0);
    checkOutput("rst done", int'(bus.done), 0);
    checkOutput("rst err", int'(bus.err), 0);
    checkOutput("rst s_ready", int'(bus.s_ready), 1);
    checkOutput("rst edits_seen", edit_q.size(), 0);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst s_ready", int'(bus.s_ready), 1);
    checkOutput("post_rst busy", int'(bus.busy), 0);

    cmd = {8'h08, 8'h5A};
    applyStimulus(cmd, 0);
    compareRun("single");
    checkOutput("single s2_lookup_001010", int'(sbox_mem[1][0][5]), 'hA);

    foreach (vecs[i]) begin
      cmd.delete();
      cmd.push_back(vecs[i].hdr);
      if (!vecs[i].rsv) cmd.push_back(vecs[i].dat);
      applyStimulus(cmd, 0);
      checkOutput($sformatf("vec%0d edit_count", i), edit_q.size(), vecs[i].rsv ? 0 : 1);
      checkOutput($sformatf("vec%0d err_count", i), err_q.size(), vecs[i].rsv ? 1 : 0);
      checkOutput($sformatf("vec%0d done_count", i), done_q.size(), vecs[i].rsv ? 0 : 1);
      if (edit_q.size() == 1)
        checkOutput($sformatf("vec%0d fields", i), int'(edit_q[0].f),
                    int'(pack_edit(vecs[i].sb, vecs[i].row, vecs[i].col, vecs[i].val)));
    end

    cmd = {8'h4E};
    for (int k = 0; k < 8; k++) cmd.push_back(8'((2 * k) * 16 + 2 * k + 1));
    applyStimulus(cmd, 0);
    compareRun("row");
    spacing_bad = 0;
    if (acc_q.size() == 9) begin
      if (acc_q[1] - acc_q[0] != 1) spacing_bad++;
      for (int k = 2; k < 9; k++) if (acc_q[k] - acc_q[k - 1] != 3) spacing_bad++;
    end
    checkOutput("row accept_spacing_errors", spacing_bad, 0);

    cmd = {8'hB8};
    for (int k = 0; k < 32; k++) cmd.push_back(8'($urandom));
    applyStimulus(cmd, 35);
    compareRun("table");
    checkOutput("table edit_count", edit_q.size(), 64);
    if (edit_q.size() == 64) begin
      checkOutput("table idx15", int'(edit_q[15].f[9:4]), int'({2'd0, 4'd15}));
      checkOutput("table idx16", int'(edit_q[16].f[9:4]), int'({2'd1, 4'd0}));
      checkOutput("table last", int'(edit_q[63].f[12:4]), int'({3'd7, 2'd3, 4'd15}));
    end

    cmd = {8'hC0, 8'h08, 8'h3C};
    applyStimulus(cmd, 0);
    compareRun("reserved");
    if (edit_q.size() == 1)
      checkOutput("reserved followup", int'(edit_q[0].f), int'(pack_edit(1, 0, 3, 'hC)));

    clear_logs();
    send_byte(8'h4E, 0);
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    send_byte(8'h45, 0);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    checkOutput("midrst edit_sbox", int'(bus.edit_sbox), 0);
    checkOutput("midrst busy", int'(bus.busy), 0);
    checkOutput("midrst s_ready", int'(bus.s_ready), 1);
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst edits_in_reset", edit_q.size(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd = {8'h08, 8'h11};
    applyStimulus(cmd, 0);
    compareRun("after_reset");

    for (int t = 0; t < 25; t++) begin
      rnd8 = 8'($urandom);
      op   = int'($urandom_range(3));
      cmd.delete();
      cmd.push_back({2'(op), rnd8[5:0]});
      nb = (op == 0) ? 1 : (op == 1) ? 8 : (op == 2) ? 32 : 0;
      for (int k = 0; k < nb; k++) cmd.push_back(8'($urandom));
      applyStimulus(cmd, (t % 2 == 0) ? 0 : 30);
      compareRun($sformatf("rand%0d", t));
    end

    checkOutput("invariants", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
